// File: rtl/vedic_mac_accum_if.sv
// Handshake/bus bundle for vedic_mac_accum: burst control, product input
// stream and accumulated-result output stream.
interface vedic_mac_accum_if #(
    parameter int unsigned ACC_W = 72,
    parameter int unsigned CNT_W = 8
);
    logic             start;
    logic [CNT_W-1:0] len;
    logic             prod_valid;
    logic             prod_ready;
    logic [63:0]      prod;
    logic             acc_valid;
    logic             acc_ready;
    logic [ACC_W-1:0] acc;
    logic             acc_ovf;
    logic             busy;

    modport master (
        output start, len, prod_valid, prod, acc_ready,
        input  prod_ready, acc_valid, acc, acc_ovf, busy
    );

    modport slave (
        input  start, len, prod_valid, prod, acc_ready,
        output prod_ready, acc_valid, acc, acc_ovf, busy
    );
endinterface

// File: rtl/vedic_mac_accum.sv
// Burst multiply-accumulate back end for the 32x32 Vedic multiplier product.
// Optional saturation on overflow: define VEDIC_MAC_SAT_EN (default wraps).
module vedic_mac_accum #(
    parameter int unsigned ACC_W = 72,
    parameter int unsigned CNT_W = 8
) (
    input logic               clk,
    input logic               rst,
    vedic_mac_accum_if.slave  bus
);
    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        HOLD
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [ACC_W-1:0] r_acc;
    logic             r_ovf;
    logic [CNT_W-1:0] r_remaining;

    logic             w_xfer;
    logic             w_start;
    logic [ACC_W:0]   w_sum;
    logic             w_carry;
    logic [ACC_W-1:0] w_acc_next;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next         = r_state;
        w_xfer         = 1'b0;
        w_start        = 1'b0;
        bus.prod_ready = 1'b0;
        bus.acc_valid  = 1'b0;
        bus.busy       = 1'b0;
        case (r_state)
            IDLE: begin
                if (bus.start) begin
                    w_start = 1'b1;
                    w_next  = (bus.len == '0) ? HOLD : ACCUM;
                end
            end
            ACCUM: begin
                bus.prod_ready = 1'b1;
                bus.busy       = 1'b1;
                w_xfer         = bus.prod_valid;
                if (w_xfer && (r_remaining == CNT_W'(1))) begin
                    w_next = HOLD;
                end
            end
            HOLD: begin
                bus.acc_valid = 1'b1;
                bus.busy      = 1'b1;
                if (bus.acc_ready) begin
                    w_next = IDLE;
                end
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    // One extra bit captures the carry out of the accumulator MSB.
    always_comb begin
        w_sum   = {1'b0, r_acc} + (ACC_W + 1)'(bus.prod);
        w_carry = w_sum[ACC_W];
`ifdef VEDIC_MAC_SAT_EN
        w_acc_next = (r_ovf || w_carry) ? '1 : w_sum[ACC_W-1:0];
`else
        w_acc_next = w_sum[ACC_W-1:0];
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc       <= '0;
            r_ovf       <= 1'b0;
            r_remaining <= '0;
        end else if (w_start) begin
            r_acc       <= '0;
            r_ovf       <= 1'b0;
            r_remaining <= bus.len;
        end else if (w_xfer) begin
            r_acc       <= w_acc_next;
            r_ovf       <= r_ovf | w_carry;
            r_remaining <= r_remaining - CNT_W'(1);
        end
    end

    assign bus.acc     = r_acc;
    assign bus.acc_ovf = r_ovf;
endmodule
